pos_tag_readout: RTL and testbench

- Drains the backtrace stack that the Viterbi datapath fills during traceback.
- Issues one-cycle pop strobes to the stack. Captures each popped POS tag (first word first, since traceback pushed last word first).
- Streams (word index, POS) pairs to the downstream consumer over a valid/ready handshake.
- Sits between the datapath's Stack_POS read side (RW_Stack_POS, final_POS, stack_empty) and the output consumer. The top-level controller kicks it with start once traceback completes.

---
 rtl/pos_tag_readout_pkg.sv | 20 ++
 rtl/pos_tag_readout.sv | 142 ++++++++++++++
 tb/tb_pos_tag_readout.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pos_tag_readout_pkg.sv
// Shared definitions for the POS tag readout block and the Viterbi datapath.
// Holds the default tag/index widths and the readout FSM state encoding.
// No logic lives here; everything is consumed through import.
package pos_tag_readout_pkg;

   // Widths shared with the datapath's Stack_POS and word counters.
   localparam int pos_num_bit_default  = 4;
   localparam int word_num_default     = 16;
   localparam int word_num_bit_default = 4;

   // Readout FSM encoding.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      POP  = 3'd1,
      CAPT = 3'd2,
      SEND = 3'd3,
      FIN  = 3'd4
   } readout_state_t;

endpackage

// File: rtl/pos_tag_readout.sv
// Purpose: drains the traceback stack, streaming (word index, POS) pairs downstream.
// Latency: start->first pop 1 cycle, pop->tag_valid 2 cycles, one tag per 3 cycles.
// Backpressure: tag_valid holds index/pos/last stable until tag_ready; no pop meanwhile.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, word_count   kick-off pulse and sentence length (sampled on start)
//   final_POS           stack read data, valid the cycle after pop
//   stack_empty         stack has no entries
//   pop                 one-cycle stack read strobe
//   tag_valid/ready     output handshake for tag_index, tag_pos, tag_last
//   busy                readout in progress (any state but IDLE)
//   complete            one-cycle pulse at the end of every sequence
//   error               sticky: stack ran dry or held residual entries
module pos_tag_readout
   import pos_tag_readout_pkg::*;
#(
   parameter int POS_num_bit  = pos_num_bit_default,
   parameter int word_num     = word_num_default,
   parameter int word_num_bit = word_num_bit_default
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [word_num_bit-1:0] word_count,
   input  logic [POS_num_bit-1:0]  final_POS,
   input  logic                    stack_empty,
   output logic                    pop,
   output logic                    tag_valid,
   input  logic                    tag_ready,
   output logic [word_num_bit-1:0] tag_index,
   output logic [POS_num_bit-1:0]  tag_pos,
   output logic                    tag_last,
   output logic                    busy,
   output logic                    complete,
   output logic                    error
);

   // The index register must be able to address the last word of a
   // maximum-length sentence.
   if (word_num > (1 << word_num_bit)) begin : g_word_num_check
      $error("pos_tag_readout: word_num exceeds the range of word_num_bit");
   end

   readout_state_t state_r;
   readout_state_t state_nxt;

   logic [word_num_bit-1:0] cnt_r;

   // Next-state and strobe outputs. pop/tag_valid/complete are decoded
   // straight from the state so they drop the cycle the state moves on.
   always_comb begin
      state_nxt = state_r;
      pop       = 1'b0;
      tag_valid = 1'b0;
      complete  = 1'b0;
      busy      = (state_r != IDLE);
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt = (word_count != '0) ? POP : FIN;
            end
         end
         POP: begin
            // An empty stack here means traceback produced fewer tags
            // than the sentence length; abandon without popping.
            if (stack_empty) begin
               state_nxt = FIN;
            end else begin
               pop       = 1'b1;
               state_nxt = CAPT;
            end
         end
         CAPT: begin
            state_nxt = SEND;
         end
         SEND: begin
            tag_valid = 1'b1;
            if (tag_ready) begin
               state_nxt = tag_last ? FIN : POP;
            end
         end
         FIN: begin
            complete  = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         tag_index <= '0;
         tag_pos   <= '0;
         tag_last  <= 1'b0;
         error     <= 1'b0;
      end else begin
         state_r <= state_nxt;
         case (state_r)
            IDLE: begin
               if (start) begin
                  error <= 1'b0;
                  if (word_count != '0) begin
                     cnt_r     <= word_count;
                     tag_index <= '0;
                  end
               end
            end
            POP: begin
               if (stack_empty) begin
                  error <= 1'b1;
               end
            end
            CAPT: begin
               // final_POS carries the word popped in the previous cycle.
               tag_pos  <= final_POS;
               tag_last <= (tag_index == (cnt_r - word_num_bit'(1)));
            end
            SEND: begin
               // The index stops on the last word, so it can never wrap.
               if (tag_ready && !tag_last) begin
                  tag_index <= tag_index + word_num_bit'(1);
               end
            end
            FIN: begin
               // Only a clean finish is checked for leftovers; an underflow
               // has already flagged the error.
               if (!error && !stack_empty) begin
                  error <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pos_tag_readout.sv
// Bench for pos_tag_readout: a behavioural stack feeds the DUT, and each
// sequence is predicted from the stack contents and the word count.
module tb_pos_tag_readout;

   localparam int PB = 4;
   localparam int WB = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [WB-1:0] word_count;
   logic [PB-1:0] final_POS;
   logic          stack_empty;
   logic          pop;
   logic          tag_valid;
   logic          tag_ready;
   logic [WB-1:0] tag_index;
   logic [PB-1:0] tag_pos;
   logic          tag_last;
   logic          busy;
   logic          complete;
   logic          error;

   always #5 clk = ~clk;

   pos_tag_readout #(.POS_num_bit(PB), .word_num(16), .word_num_bit(WB)) dut (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count),
      .final_POS(final_POS), .stack_empty(stack_empty), .pop(pop),
      .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_index(tag_index),
      .tag_pos(tag_pos), .tag_last(tag_last), .busy(busy),
      .complete(complete), .error(error)
   );

   typedef struct packed {
      logic [WB-1:0] idx;
      logic [PB-1:0] pos;
      logic          last;
   } tag_t;

   typedef struct {
      int wc;
      int depth;
      bit rnd;
      int exp_err;
      int exp_tags;
   } vec_t;

   tag_t          got_q[$];
   tag_t          exp_q[$];
   logic [PB-1:0] stack_q[$];
   int            pop_cyc[$];
   int            cmp_cnt;
   int            cmp_cyc;
   int            cyc;
   int            exp_err;
   int            exp_pops;
   int            exp_left;
   int            exp_cmp_cyc;
   bit            timing_chk;
   bit            rand_ready = 1'b0;
   logic          pop_seen = 1'b0;
   bit            hold_v = 1'b0;
   tag_t          held;
   int            compared = 0;
   int            mismatched = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Observe at the falling edge, away from the DUT's active edge.
   always @(negedge clk) begin
      pop_seen = pop;
      if (pop) pop_cyc.push_back(cyc);
      if (complete) begin
         cmp_cnt++;
         cmp_cyc = cyc;
      end
      if (hold_v) begin
         chk("hold_valid", 32'(tag_valid), 32'd1);
         chk("hold_tag", 32'({tag_index, tag_pos, tag_last}), 32'(held));
      end
      if (tag_valid && tag_ready) got_q.push_back(tag_t'{tag_index, tag_pos, tag_last});
      hold_v = tag_valid && !tag_ready && !reset;
      held   = tag_t'{tag_index, tag_pos, tag_last};
      cyc++;
   end

   // Stack model: a pop seen in one cycle presents its data in the next.
   always @(posedge clk) begin
      #1;
      if (pop_seen && stack_q.size() > 0) final_POS = stack_q.pop_front();
      stack_empty = (stack_q.size() == 0);
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #2;
         tag_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic load_rand(input int depth);
      stack_q.delete();
      for (int i = 0; i < depth; i++) stack_q.push_back(PB'($urandom_range(0, 15)));
      stack_empty = (stack_q.size() == 0);
   endtask

   task automatic end_rand();
      rand_ready = 1'b0;
      step(1);
      tag_ready = 1'b1;
   endtask

   // Predict the whole sequence from the stack and word count, then kick.
   task automatic begin_seq(input int wc);
      int depth;
      int n;
      depth = stack_q.size();
      n     = (wc < depth) ? wc : depth;
      exp_q.delete();
      got_q.delete();
      pop_cyc.delete();
      cmp_cnt = 0;
      cmp_cyc = -1;
      for (int i = 0; i < n; i++) exp_q.push_back(tag_t'{WB'(i), stack_q[i], (i == wc - 1)});
      exp_pops    = n;
      exp_err     = (wc != depth) ? 1 : 0;
      exp_left    = depth - n;
      exp_cmp_cyc = (wc <= depth) ? 3 * wc + 1 : 3 * depth + 2;
      timing_chk  = !rand_ready;
      start       = 1'b1;
      word_count  = WB'(wc);
      cyc         = 0;
      step(1);
      start       = 1'b0;
   endtask

   task automatic finish_seq();
      int n;
      for (int i = 0; i < 400 && cmp_cnt == 0; i++) @(posedge clk);
      #2;
      chk("complete_seen", cmp_cnt, 1);
      chk("busy_after", 32'(busy), 0);
      chk("error", 32'(error), exp_err);
      chk("pop_count", pop_cyc.size(), exp_pops);
      chk("tag_count", got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk($sformatf("tag%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
      chk("stack_left", stack_q.size(), exp_left);
      if (timing_chk) begin
         chk("complete_cycle", cmp_cyc, exp_cmp_cyc);
         for (int k = 0; k < pop_cyc.size(); k++) chk($sformatf("pop%0d_cycle", k), pop_cyc[k], 1 + 3 * k);
      end
   endtask

   task automatic chk_reset_vals(input string p);
      chk({p, "_pop"}, 32'(pop), 0);
      chk({p, "_tag_valid"}, 32'(tag_valid), 0);
      chk({p, "_tag_index"}, 32'(tag_index), 0);
      chk({p, "_tag_pos"}, 32'(tag_pos), 0);
      chk({p, "_tag_last"}, 32'(tag_last), 0);
      chk({p, "_busy"}, 32'(busy), 0);
      chk({p, "_complete"}, 32'(complete), 0);
      chk({p, "_error"}, 32'(error), 0);
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{3, 3, 1'b0, 0, 3};
      vecs[1] = '{4, 2, 1'b0, 1, 2};
      vecs[2] = '{2, 3, 1'b0, 1, 2};
      vecs[3] = '{0, 0, 1'b0, 0, 0};
      vecs[4] = '{0, 2, 1'b0, 1, 0};
      vecs[5] = '{15, 15, 1'b0, 0, 15};
      vecs[6] = '{15, 15, 1'b1, 0, 15};
      vecs[7] = '{1, 1, 1'b1, 0, 1};

      reset = 1'b1; start = 1'b0; word_count = '0; final_POS = '0;
      stack_empty = 1'b1; tag_ready = 1'b1;
      step(2);
      chk_reset_vals("reset");
      reset = 1'b0;
      step(1);

      // Basic three-word sentence with the consumer always ready.
      stack_q = {4'd3, 4'd7, 4'd1};
      stack_empty = 1'b0;
      begin_seq(3);
      finish_seq();
      chk("t1_stack_empty", 32'(stack_empty), 1);
      if (got_q.size() == 3) begin
         chk("t1_last_tag", 32'(got_q[2]), 32'({4'd2, 4'd1, 1'b1}));
         chk("t1_mid_tag", 32'(got_q[1]), 32'({4'd1, 4'd7, 1'b0}));
      end

      // Consumer stalls on the second tag for five cycles.
      stack_q = {4'd3, 4'd7, 4'd1};
      stack_empty = 1'b0;
      begin_seq(3);
      timing_chk = 1'b0;
      step(3);
      tag_ready = 1'b0;
      step(4);
      chk("t2_valid_held", 32'(tag_valid), 1);
      chk("t2_idx_held", 32'(tag_index), 1);
      chk("t2_pos_held", 32'(tag_pos), 7);
      chk("t2_no_extra_pop", pop_cyc.size(), 2);
      step(3);
      tag_ready = 1'b1;
      finish_seq();
      chk("t2_third_pop_cycle", (pop_cyc.size() == 3) ? pop_cyc[2] : -1, 12);

      // Table of sentence length / stack depth combinations.
      foreach (vecs[v]) begin
         load_rand(vecs[v].depth);
         rand_ready = vecs[v].rnd;
         tag_ready  = 1'b1;
         begin_seq(vecs[v].wc);
         finish_seq();
         chk($sformatf("vec%0d_error", v), 32'(error), vecs[v].exp_err);
         chk($sformatf("vec%0d_tags", v), got_q.size(), vecs[v].exp_tags);
         end_rand();
      end

      // A second start while busy must be ignored.
      load_rand(3);
      begin_seq(3);
      step(2);
      start = 1'b1;
      word_count = 4'd1;
      step(1);
      start = 1'b0;
      finish_seq();
      step(2);
      chk("busy_start_no_restart", 32'(busy), 0);

      // Reset while the second tag of a four-word run is on offer.
      load_rand(4);
      begin_seq(4);
      step(5);
      chk("rst_in_send", 32'(tag_valid), 1);
      reset = 1'b1;
      step(1);
      chk_reset_vals("midrst");
      reset = 1'b0;
      step(1);
      load_rand(4);
      begin_seq(4);
      finish_seq();

      // Randomised sentences, stack depths and consumer stalls.
      for (int r = 0; r < 20; r++) begin
         int wc;
         int depth;
         wc    = $urandom_range(0, 15);
         depth = ($urandom_range(0, 1) == 1) ? wc : $urandom_range(0, 15);
         load_rand(depth);
         rand_ready = ($urandom_range(0, 1) == 1);
         tag_ready  = 1'b1;
         begin_seq(wc);
         finish_seq();
         end_rand();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
